// File: rtl/cnu_sched_if.sv
// Handshake bundle between the layered-decoder scheduler and its cnu datapath / host.
`timescale 1ns/1ps
interface cnu_sched_if #(
    parameter int lay_w = 2,
    parameter int it_w  = 3
);
    logic             start;
    logic             cnu_en;
    logic             rd_valid;
    logic [lay_w-1:0] rd_addr;
    logic             wr_en;
    logic [lay_w-1:0] wr_addr;
    logic             par_ok;
    logic [it_w-1:0]  iter;
    logic             busy;
    logic             done;
    logic             converged;

    modport master (
        input  start, par_ok,
        output cnu_en, rd_valid, rd_addr, wr_en, wr_addr, iter, busy, done, converged
    );

    modport slave (
        output start, par_ok,
        input  cnu_en, rd_valid, rd_addr, wr_en, wr_addr, iter, busy, done, converged
    );
endinterface

// File: rtl/cnu_sched.sv
// Layer/iteration scheduler for a layered check-node decoder: issues NL layers per
// iteration, tracks parity of write-backs and stops on convergence or MAX_IT.
`timescale 1ns/1ps
module cnu_sched #(
    parameter int NL     = 4,
    parameter int MAX_IT = 8,
    parameter int PIPE   = 2,
    parameter int lay_w  = 2,
    parameter int it_w   = 3
) (
    input  logic        clk,
    input  logic        rst,
    cnu_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DC_W = (PIPE > 1) ? $clog2(PIPE) : 1;

    state_t           state;
    logic [lay_w-1:0] lay_cnt;
    logic [DC_W-1:0]  drain_cnt;
    logic [it_w-1:0]  iter_q;
    logic             all_ok;
    logic             converged_q;
    logic             done_q;
    logic             busy_q;
    logic             rd_valid_q;

    logic             wr_vld_p  [PIPE];
    logic [lay_w-1:0] wr_addr_p [PIPE];

    logic             wr_en;
    logic             final_ok;

    assign wr_en    = wr_vld_p[PIPE-1];
    // The last write of an iteration lands in the final DRAIN cycle, so its parity
    // has to be folded in combinationally rather than through all_ok.
    assign final_ok = all_ok & (bus.par_ok | ~wr_en);

    // Write-back delay line: issue -> write-back after exactly PIPE cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                wr_vld_p[i]  <= 1'b0;
                wr_addr_p[i] <= '0;
            end
        end else begin
            wr_vld_p[0]  <= rd_valid_q;
            wr_addr_p[0] <= lay_cnt;
            for (int i = 1; i < PIPE; i++) begin
                wr_vld_p[i]  <= wr_vld_p[i-1];
                wr_addr_p[i] <= wr_addr_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lay_cnt     <= '0;
            drain_cnt   <= '0;
            iter_q      <= '0;
            all_ok      <= 1'b1;
            converged_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            if (wr_en && !bus.par_ok)
                all_ok <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        lay_cnt     <= '0;
                        iter_q      <= '0;
                        all_ok      <= 1'b1;
                        converged_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rd_valid_q  <= 1'b1;
                    end
                end

                RUN: begin
                    if (lay_cnt == lay_w'(NL - 1)) begin
                        lay_cnt    <= '0;
                        drain_cnt  <= '0;
                        rd_valid_q <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        lay_cnt <= lay_cnt + lay_w'(1);
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DC_W'(PIPE - 1)) begin
                        drain_cnt <= '0;
                        if (final_ok) begin
                            converged_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state       <= DONE;
                        end else if (iter_q == it_w'(MAX_IT - 1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            iter_q     <= iter_q + it_w'(1);
                            all_ok     <= 1'b1;
                            rd_valid_q <= 1'b1;
                            state      <= RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The cnu pipeline runs exactly while the scheduler is busy.
    assign bus.cnu_en    = busy_q;
    assign bus.busy      = busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_addr   = lay_cnt;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr_p[PIPE-1];
    assign bus.iter      = iter_q;
    assign bus.done      = done_q;
    assign bus.converged = converged_q;
endmodule

// File: tb/tb_cnu_sched.sv
// Bench for cnu_sched: table of parity-failure scenarios plus hand sequences for
// held start and asynchronous reset mid-RUN.
`timescale 1ns/1ps
module tb_cnu_sched;
    localparam int NL = 4, MAX_IT = 8, PIPE = 2, LW = 2, IW = 3;

    logic clk = 1'b0;
    logic rst;

    cnu_sched_if #(.lay_w(LW), .it_w(IW)) bus ();

    cnu_sched #(.NL(NL), .MAX_IT(MAX_IT), .PIPE(PIPE), .lay_w(LW), .it_w(IW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [LW-1:0] addr;
        int            due;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string name;
        int    fail_iters;   // iterations (from 0) in which the chosen layer fails parity
        int    fail_layer;   // -1: every layer fails in those iterations
        int    exp_done;
        int    exp_iter;
        int    exp_conv;
        int    exp_wr;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_decode(input vec_t v);
        int  cyc, rd_cnt, wr_cnt, done_cyc;
        sb_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.par_ok = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cyc = -1;
        sb_q.delete();
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({v.name, " converged_cleared"}, bus.converged, 0);
                check({v.name, " iter_start"}, bus.iter, 0);
            end
            if (bus.rd_valid) begin
                check({v.name, " rd_addr"}, bus.rd_addr, rd_cnt % NL);
                e.addr = LW'(rd_cnt % NL);
                e.due  = cyc + PIPE;
                sb_q.push_back(e);
                rd_cnt++;
            end
            if (bus.wr_en) begin
                if (sb_q.size() == 0) begin
                    check({v.name, " wr_unexpected"}, 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check({v.name, " wr_addr"}, bus.wr_addr, e.addr);
                    check({v.name, " wr_cycle"}, cyc, e.due);
                end
                bus.par_ok = !(((wr_cnt / NL) < v.fail_iters) &&
                               (v.fail_layer < 0 || (wr_cnt % NL) == v.fail_layer));
                wr_cnt++;
            end else begin
                bus.par_ok = ($urandom_range(0, 1) == 1);
            end
            if (bus.done) done_cyc = cyc;
        end
        check({v.name, " done_cycle"}, done_cyc, v.exp_done);
        check({v.name, " iter"}, bus.iter, v.exp_iter);
        check({v.name, " converged"}, bus.converged, v.exp_conv);
        check({v.name, " wr_count"}, wr_cnt, v.exp_wr);
        check({v.name, " sb_empty"}, sb_q.size(), 0);
        check({v.name, " busy_in_done"}, {bus.busy, bus.cnu_en, bus.wr_en, bus.rd_valid}, 0);
        @(negedge clk);
        check({v.name, " idle_done_low"}, bus.done, 0);
        check({v.name, " idle_iter_hold"}, bus.iter, v.exp_iter);
        check({v.name, " idle_conv_hold"}, bus.converged, v.exp_conv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at;
        vecs[0] = '{"conv_first",    0, -1,  7, 0, 1,  4};
        vecs[1] = '{"never_conv",    8, -1, 49, 7, 0, 32};
        vecs[2] = '{"fail_l2_it0",   1,  2, 13, 1, 1,  8};
        vecs[3] = '{"fail_last_l",   3,  3, 25, 3, 1, 16};
        vecs[4] = '{"conv_last_it",  7,  0, 49, 7, 1, 32};
        vecs[5] = '{"fail_all_2it",  2, -1, 19, 2, 1, 12};

        rst = 1'b1;
        bus.start  = 1'b0;
        bus.par_ok = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.rd_valid, bus.wr_en, bus.cnu_en, bus.busy, bus.done,
                                bus.converged, bus.iter, bus.rd_addr, bus.wr_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_quiet", {bus.rd_valid, bus.wr_en, bus.busy, bus.done}, 0);

        for (int i = 0; i < 6; i++) run_decode(vecs[i]);

        // start held high across the whole decode and DONE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.par_ok = 1'b1;
        @(posedge clk);
        done_at = -1;
        for (int c = 1; c <= 30 && done_at < 0; c++) begin
            @(negedge clk);
            if (c <= 12) begin
                check("held_rd_valid", bus.rd_valid, (c <= 4) || (c >= 9));
                check("held_busy", bus.busy, (c <= 6) || (c >= 9));
                check("held_done", bus.done, c == 7);
            end
            if (c == 12) bus.start = 1'b0;
            if (c > 12 && bus.done) done_at = c;
        end
        check("held_second_done", done_at, 15);

        // asynchronous reset in the fourth RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_wr_en", bus.wr_en, 1);
        check("pre_rst_rd_addr", bus.rd_addr, 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {bus.rd_valid, bus.wr_en, bus.cnu_en, bus.busy, bus.done,
                                    bus.converged, bus.iter, bus.rd_addr, bus.wr_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_quiet", {bus.wr_en, bus.rd_valid, bus.busy}, 0);
        end
        run_decode(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
